// File: rtl/vec_pkg.sv
// Shared types for the vector accelerator host driver: opcodes and FSM states.
package vec_pkg;

  localparam int unsigned op_width = 3;

  typedef enum logic [op_width-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_MUL   = 3'd4,
    OP_SMUL  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_DONE  = 2'd2,
    WAIT_STORE = 2'd3
  } state_e;

endpackage

// File: rtl/vec_host_driver_if.sv
// Accelerator-facing command/readback bus; master is the host driver, slave the accelerator.
interface vec_host_driver_if
  import vec_pkg::*;
#(
  parameter int unsigned els_p  = 32,
  parameter int unsigned vlen_p = 8,
  parameter int unsigned vdw_p  = 8
) ();

  localparam int unsigned aw_lp = $clog2(els_p);
  localparam int unsigned dw_lp = vlen_p * vdw_p;

  logic [aw_lp-1:0] addrA;
  logic [aw_lp-1:0] addrB;
  logic [aw_lp-1:0] addrC;
  logic [vdw_p-1:0] scalar;
  logic [dw_lp-1:0] w_data;
  op_e              op;
  logic             v;
  logic             ready;
  logic             done;
  logic [dw_lp-1:0] r_data;
  logic             r_v;
  logic             yumi;

  modport master (
    output addrA, addrB, addrC, scalar, w_data, op, v, yumi,
    input  ready, done, r_data, r_v
  );

  modport slave (
    input  addrA, addrB, addrC, scalar, w_data, op, v, yumi,
    output ready, done, r_data, r_v
  );

endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with registered full/empty flags; used to buffer store read data.
module bsg_two_fifo #(
  parameter int unsigned width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic               r_full;
  logic               r_empty;
  logic               w_push;
  logic               w_pop;

  assign w_push  = v_i & ~r_full;
  assign w_pop   = yumi_i & ~r_empty;
  assign ready_o = ~r_full;
  assign v_o     = ~r_empty;
  assign data_o  = r_mem[r_rptr];

  // Storage: no reset needed, validity is tracked by the flags below.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Pointers and occupancy flags; reset discards anything buffered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      if (w_push && !w_pop) begin
        r_empty <= 1'b0;
        r_full  <= ~r_empty;
      end else if (w_pop && !w_push) begin
        r_full  <= 1'b0;
        r_empty <= ~r_full;
      end
    end
  end

endmodule

// File: rtl/vec_host_driver.sv
// Host-side initiator: issues one command at a time to the vector accelerator,
// tracks completion, buffers store read data and reports timeouts.
module vec_host_driver
  import vec_pkg::*;
#(
  parameter int unsigned els_p       = 32,
  parameter int unsigned vlen_p      = 8,
  parameter int unsigned vdw_p       = 8,
  parameter int unsigned timeout_p   = 1024,
  parameter int unsigned cnt_width_p = 16,
  localparam int unsigned aw_lp      = $clog2(els_p),
  localparam int unsigned dw_lp      = vlen_p * vdw_p
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cmd_v_i,
  input  op_e                    cmd_op_i,
  input  logic [aw_lp-1:0]       cmd_addrA_i,
  input  logic [aw_lp-1:0]       cmd_addrB_i,
  input  logic [aw_lp-1:0]       cmd_addrC_i,
  input  logic [vdw_p-1:0]       cmd_scalar_i,
  input  logic [dw_lp-1:0]       cmd_w_data_i,
  output logic                   cmd_ready_o,
  vec_host_driver_if.master      acc,
  output logic [dw_lp-1:0]       resp_data_o,
  output logic                   resp_v_o,
  input  logic                   resp_yumi_i,
  output logic [cnt_width_p-1:0] issued_o,
  output logic [cnt_width_p-1:0] completed_o,
  output logic                   error_o
);

  localparam int unsigned tmo_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;

  state_e                 r_state;
  logic [aw_lp-1:0]       r_addrA;
  logic [aw_lp-1:0]       r_addrB;
  logic [aw_lp-1:0]       r_addrC;
  logic [vdw_p-1:0]       r_scalar;
  logic [dw_lp-1:0]       r_w_data;
  op_e                    r_op;
  logic                   r_acc_v;
  logic                   r_got_data;
  logic                   r_got_done;
  logic [tmo_w_lp-1:0]    r_tmo;
  logic [cnt_width_p-1:0] r_issued;
  logic [cnt_width_p-1:0] r_completed;
  logic                   r_error;

  logic w_fifo_ready;
  logic w_yumi;
  logic w_data_ok;
  logic w_done_ok;
  logic w_tmo_inc;
  logic w_tmo_hit;

  // Read data is taken only while waiting for a store, once, and only if it can be buffered.
  assign w_yumi    = (r_state == WAIT_STORE) & acc.r_v & w_fifo_ready & ~r_got_data;
  assign w_data_ok = r_got_data | w_yumi;
  assign w_done_ok = r_got_done | acc.done;
  // A full response buffer is upstream backpressure, not an accelerator stall.
  assign w_tmo_inc = (r_state != IDLE) & ~((r_state == WAIT_STORE) & ~w_fifo_ready);
  assign w_tmo_hit = w_tmo_inc & (r_tmo == tmo_w_lp'(timeout_p - 1));

  assign cmd_ready_o = (r_state == IDLE);
  assign acc.addrA   = r_addrA;
  assign acc.addrB   = r_addrB;
  assign acc.addrC   = r_addrC;
  assign acc.scalar  = r_scalar;
  assign acc.w_data  = r_w_data;
  assign acc.op      = r_op;
  assign acc.v       = r_acc_v;
  assign acc.yumi    = w_yumi;
  assign issued_o    = r_issued;
  assign completed_o = r_completed;
  assign error_o     = r_error;

  // Command FSM: accept, issue, then wait for done (and store data) or time out.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_addrA     <= '0;
      r_addrB     <= '0;
      r_addrC     <= '0;
      r_scalar    <= '0;
      r_w_data    <= '0;
      r_op        <= OP_LOAD;
      r_acc_v     <= 1'b0;
      r_got_data  <= 1'b0;
      r_got_done  <= 1'b0;
      r_tmo       <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_v_i) begin
            r_addrA  <= cmd_addrA_i;
            r_addrB  <= cmd_addrB_i;
            r_addrC  <= cmd_addrC_i;
            r_scalar <= cmd_scalar_i;
            r_w_data <= cmd_w_data_i;
            r_op     <= cmd_op_i;
            r_acc_v  <= 1'b1;
            r_tmo    <= '0;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (acc.ready) begin
            r_acc_v    <= 1'b0;
            r_issued   <= r_issued + cnt_width_p'(1);
            r_tmo      <= '0;
            r_got_data <= 1'b0;
            r_got_done <= 1'b0;
            r_state    <= (r_op == OP_STORE) ? WAIT_STORE : WAIT_DONE;
          end else if (w_tmo_hit) begin
            r_acc_v <= 1'b0;
            r_error <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + tmo_w_lp'(1);
          end
        end
        WAIT_DONE: begin
          if (acc.done) begin
            r_completed <= r_completed + cnt_width_p'(1);
            r_state     <= IDLE;
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + tmo_w_lp'(1);
          end
        end
        WAIT_STORE: begin
          if (w_data_ok && w_done_ok) begin
            r_completed <= r_completed + cnt_width_p'(1);
            r_state     <= IDLE;
          end else begin
            if (w_yumi) begin
              r_got_data <= 1'b1;
            end
            if (acc.done) begin
              r_got_done <= 1'b1;
            end
            if (w_tmo_hit) begin
              r_error <= 1'b1;
              r_state <= IDLE;
            end else if (w_tmo_inc) begin
              r_tmo <= r_tmo + tmo_w_lp'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  bsg_two_fifo #(
    .width_p (dw_lp)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (acc.r_data),
    .v_i     (w_yumi),
    .ready_o (w_fifo_ready),
    .data_o  (resp_data_o),
    .v_o     (resp_v_o),
    .yumi_i  (resp_yumi_i)
  );

endmodule
